// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: MIPS opcodes and the
// sequencer state encoding.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle between the sequencer and the datapath.
// master: the sequencer (samples decode fields / memory status, drives the
//         stage enables, flushes, memory request, error and perf counter).
// slave : the datapath side (drives decode fields / memory status).
interface pipe_ctrl_if;
    logic [5:0]  opcode_id;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic [5:0]  opcode_ex;
    logic [4:0]  rt_ex;
    logic        branch_taken_ex;
    logic        mem_access_mm;
    logic        mem_ready;
    logic        mem_req;
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_en;
    logic        id_ex_flush;
    logic        ex_mm_en;
    logic        mm_wb_en;
    logic        mm_wb_flush;
    logic        mem_err;
    logic [31:0] perf_stall_cnt;

    modport master (
        input  opcode_id, rs_id, rt_id, opcode_ex, rt_ex,
               branch_taken_ex, mem_access_mm, mem_ready,
        output mem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mm_en, mm_wb_en, mm_wb_flush, mem_err, perf_stall_cnt
    );

    modport slave (
        output opcode_id, rs_id, rt_id, opcode_ex, rt_ex,
               branch_taken_ex, mem_access_mm, mem_ready,
        input  mem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mm_en, mm_wb_en, mm_wb_flush, mem_err, perf_stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard detector.
// Ports: opcode_id/rs_id/rt_id (instruction in ID), opcode_ex/rt_ex
// (instruction in EX); load_use is high when the ID instruction reads the
// register a load in EX has not yet produced.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [5:0] opcode_id,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic [5:0] opcode_ex,
    input  logic [4:0] rt_ex,
    output logic       load_use
);
    logic id_uses_rt;

    // rt is a source for R-type, stores and compare-branches; for loads and
    // immediates it is the destination, so a match there is not a hazard.
    assign id_uses_rt = (opcode_id == OP_RTYPE) || (opcode_id == OP_SW) ||
                        (opcode_id == OP_BEQ)   || (opcode_id == OP_BNE);

    // $zero never carries a dependency.
    assign load_use = (opcode_ex == OP_LW) && (rt_ex != 5'd0) &&
                      ((rt_ex == rs_id) || (id_uses_rt && (rt_ex == rt_id)));
endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage MIPS pipeline: drives PC and stage
// register enables/flushes, owns the data-memory request and a timeout
// watchdog. Priority: memory wait > taken branch > load-use stall.
// Ports: clk, rst (synchronous, active high), bus (pipe_ctrl_if.master).
// Parameters: MEM_TIMEOUT (max MEM_WAIT cycles, 1..255), CNT_W (counter width).
// Optional: define PIPE_CTRL_PERF_EN to build the stall-cycle counter;
// otherwise perf_stall_cnt is tied to zero.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    pipe_state_t      state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             load_use;
    logic             mem_hold;

    logic mem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic ex_mm_en, mm_wb_en, mm_wb_flush;

    hazard_detect u_hazard (
        .opcode_id (bus.opcode_id),
        .rs_id     (bus.rs_id),
        .rt_id     (bus.rt_id),
        .opcode_ex (bus.opcode_ex),
        .rt_ex     (bus.rt_ex),
        .load_use  (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        mem_hold    = 1'b0;
        mem_req     = 1'b0;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mm_en    = 1'b1;
        mm_wb_en    = 1'b1;
        mm_wb_flush = 1'b0;

        unique case (state_q)
            RUN: begin
                mem_req = bus.mem_access_mm;
                if (bus.mem_access_mm && !bus.mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_W'(1);
                    mem_hold   = 1'b1;
                end else if (bus.branch_taken_ex) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Branch and load-use are not evaluated here: EX is frozen and
                // they are picked up once the pipeline is back in RUN.
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_CNT) begin
                    // Abort: release the pipeline as if the access completed.
                    mem_err_d  = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    mem_hold   = 1'b1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        // Freeze upstream stages; the MM/WB bubble stops a repeated write-back.
        if (mem_hold) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mm_en    = 1'b0;
            mm_wb_flush = 1'b1;
        end

        if (rst) begin
            mem_req     = 1'b0;
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b0;
            id_ex_flush = 1'b1;
            ex_mm_en    = 1'b0;
            mm_wb_en    = 1'b0;
            mm_wb_flush = 1'b1;
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.pc_en       = pc_en;
    assign bus.if_id_en    = if_id_en;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_en    = id_ex_en;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.ex_mm_en    = ex_mm_en;
    assign bus.mm_wb_en    = mm_wb_en;
    assign bus.mm_wb_flush = mm_wb_flush;
    assign bus.mem_err     = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (!pc_en) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = perf_q;
`else
    assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    localparam int unsigned TMO = 4;

    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_ctrl_if bus();

    pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {mem_req,pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mm_en,
    //  mm_wb_en,mm_wb_flush,mem_err,perf_stall_cnt}
    logic [41:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    // Reference model: is a memory access outstanding, how many MEM_WAIT
    // cycles have elapsed, sticky error, stall-cycle total.
    bit          m_wait = 0;
    int          m_n    = 0;
    bit          m_err  = 0;
    logic [31:0] m_perf = '0;

    task automatic step(input logic r, input logic [5:0] oid, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [5:0] oex, input logic [4:0] rtex,
                        input logic br, input logic acc, input logic rdy);
        bit lu, uses_rt, finishing, stall_mem;
        logic req, pc, ifen, iffl, exen, exfl, mmen, mwen, mwfl;
        rst = r;
        bus.opcode_id = oid; bus.rs_id = rs; bus.rt_id = rt;
        bus.opcode_ex = oex; bus.rt_ex = rtex; bus.branch_taken_ex = br;
        bus.mem_access_mm = acc; bus.mem_ready = rdy;

        uses_rt   = (oid == 6'h00) || (oid == SW) || (oid == BEQ) || (oid == BNE);
        lu        = (oex == LW) && (rtex != 0) && (rtex == rs || (uses_rt && rtex == rt));
        finishing = m_wait && (rdy || m_n == int'(TMO) - 1);
        stall_mem = m_wait ? !finishing : (acc && !rdy);

        {pc, ifen, exen, mmen, mwen} = 5'b11111;
        {iffl, exfl, mwfl} = 3'b000;
        req = m_wait ? 1'b1 : acc;
        if (stall_mem) begin
            {pc, ifen, exen, mmen} = 4'b0000;
            mwfl = 1'b1;
        end else if (!m_wait && br) begin
            {iffl, exfl} = 2'b11;
        end else if (!m_wait && lu) begin
            {pc, ifen} = 2'b00;
            exfl = 1'b1;
        end
        if (r) begin
            req = 0;
            {pc, ifen, exen, mmen, mwen} = 5'b00000;
            {iffl, exfl, mwfl} = 3'b111;
        end
        exp_q.push_back({req, pc, ifen, iffl, exen, exfl, mmen, mwen, mwfl, m_err, m_perf});

        @(posedge clk);
        if (r) begin
            m_wait = 0; m_n = 0; m_err = 0; m_perf = '0;
        end else begin
`ifdef PIPE_CTRL_PERF_EN
            if (!pc) m_perf = m_perf + 32'd1;
`endif
            if (m_wait) begin
                if (finishing) begin
                    m_wait = 0;
                    if (!rdy) m_err = 1;
                end else begin
                    m_n++;
                end
            end else if (acc && !rdy) begin
                m_wait = 1;
                m_n = 0;
            end
        end
        #1;
    endtask

    // Monitor: outputs are valid every cycle, sample mid-cycle.
    initial begin
        logic [41:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.mem_req, bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                     bus.id_ex_flush, bus.ex_mm_en, bus.mm_wb_en, bus.mm_wb_flush,
                     bus.mem_err, bus.perf_stall_cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL ctrl_outs t=%0t ctrl got=%b exp=%b perf got=%0d exp=%0d",
                             $time, a[41:32], e[41:32], a[31:0], e[31:0]);
                end
            end
        end
    end

    initial begin
        logic [5:0] ops[6];
        logic [5:0] oid, oex;
        logic br, acc, rdy, r;
        ops[0] = 6'h00; ops[1] = LW; ops[2] = SW; ops[3] = BEQ; ops[4] = BNE; ops[5] = 6'h08;
        bus.opcode_id = 0; bus.rs_id = 0; bus.rt_id = 0; bus.opcode_ex = 0; bus.rt_ex = 0;
        bus.branch_taken_ex = 0; bus.mem_access_mm = 0; bus.mem_ready = 0;
        @(posedge clk); #1;

        // reset
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0);
        // load-use, then the bubble, then rt_ex = 0 (no stall)
        step(0, 6'h00, 5, 1, LW, 5, 0, 0, 0);
        step(0, 6'h00, 5, 1, 6'h00, 0, 0, 0, 0);
        step(0, 6'h00, 0, 0, LW, 0, 0, 0, 0);
        // rt match only counts when ID reads rt
        step(0, SW, 1, 7, LW, 7, 0, 0, 0);
        step(0, LW, 1, 7, LW, 7, 0, 0, 0);
        // branch, and branch with load-use
        step(0, 6'h00, 1, 2, 6'h00, 3, 1, 0, 0);
        step(0, 6'h00, 5, 1, LW, 5, 1, 0, 0);
        // memory wait: 3 frozen cycles then ready; branch ignored while waiting
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // access completing immediately
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        // timeout, then sticky error
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 6'h00, 5, 1, LW, 5, 0, 0, 0);
        // reset mid-wait
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(79) == 0);
            oid = ops[$urandom_range(5)];
            oex = ops[$urandom_range(5)];
            br  = ($urandom_range(5) == 0);
            acc = m_wait ? 1'b1 : ($urandom_range(2) == 0);
            rdy = m_wait ? ($urandom_range(3) == 0) : $urandom_range(1);
            // keep hazards out of the cycle that leaves MEM_WAIT
            if (m_wait && (rdy || m_n == int'(TMO) - 1)) begin
                br  = 0;
                oex = 6'h00;
            end
            step(r, oid, 5'($urandom_range(3)), 5'($urandom_range(3)), oex,
                 5'($urandom_range(3)), br, acc, rdy);
        end

        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS pipeline.
- Drives enable/flush controls for the PC and for the IF/ID, ID/EX, EX/MM and MM/WB registers.
- Resolves, in priority order: multi-cycle data-memory wait, taken-branch flush, load-use stall.
- Owns the data-memory request handshake and a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 255, max cycles spent in MEM_WAIT before abort (1..255).
- CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- opcode_id  in  6  opcode of the instruction in ID
- rs_id  in  5  rs field in ID
- rt_id  in  5  rt field in ID
- opcode_ex  in  6  opcode in EX
- rt_ex  in  5  rt (load destination) in EX
- branch_taken_ex  in  1  branch in EX resolved taken
- mem_access_mm  in  1  lw/sw occupies MM this cycle
- mem_ready  in  1  data memory completes the access this cycle
- mem_req  out  1  data-memory request strobe
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID register load NOP
- id_ex_en  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX register load NOP
- ex_mm_en  out  1  EX/MM register enable
- mm_wb_en  out  1  MM/WB register enable
- mm_wb_flush  out  1  MM/WB register load NOP
- mem_err  out  1  sticky memory-timeout flag
- perf_stall_cnt  out  32  stall-cycle counter (optional feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Opcodes: LW=6'h23, SW=6'h2B, BEQ=6'h04, BNE=6'h05, R-type=6'h00.
- ID uses rt when opcode_id is R-type, SW, BEQ or BNE.
- States: RUN, MEM_WAIT (2-bit encoding, registered). wait_cnt is CNT_W bits.
- Reset (rst=1 at an edge):
  - state<=RUN, wait_cnt<=0, mem_err<=0, perf_stall_cnt<=0.
  - While rst is high: all *_en=0, all *_flush=1, mem_req=0.
  - Reset mid-wait abandons the access in the same cycle.
- Outputs are combinational from the registered state and the current inputs. No latency is added.
- Default in RUN: all *_en=1, all *_flush=0.
- Memory, priority 1:
  - In RUN, mem_req=mem_access_mm.
  - If mem_access_mm=1 and mem_ready=0: go to MEM_WAIT, wait_cnt<=1. In that same cycle pc_en, if_id_en, id_ex_en and ex_mm_en are 0, and mm_wb_flush=1.
  - If mem_ready=1 in the same cycle: no stall.
- In MEM_WAIT:
  - mem_req=1; pc/if_id/id_ex/ex_mm enables 0; mm_wb_flush=1. The bubble prevents a duplicate write-back.
  - mem_ready=1: return to RUN. That cycle uses RUN-rule outputs except mem_req=1, and mm_wb captures the result.
  - mem_ready=0 and wait_cnt==MEM_TIMEOUT: set mem_err, go to RUN, treat the access as complete (data invalid).
  - Otherwise wait_cnt++.
  - branch_taken_ex is ignored while in MEM_WAIT. The EX stage is frozen, so the branch is reacted to after the return to RUN.
- Branch, priority 2 (RUN, no memory stall): branch_taken_ex=1 sets if_id_flush=1 and id_ex_flush=1; all enables stay 1.
- Load-use, priority 3: applies when opcode_ex==LW, rt_ex!=0, and either rt_ex==rs_id or (rt_ex==rt_id and ID uses rt). Then pc_en=0, if_id_en=0 and id_ex_flush=1 for exactly one cycle.
- Simultaneous branch and load-use: the branch wins (the ID instruction is flushed anyway).
- mem_err clears only on rst.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: perf_stall_cnt increments (wrapping at 2^32) each non-reset cycle in which pc_en=0.
- Undefined: perf_stall_cnt is tied to 0 and no counter flops exist.

Decomposition:
- Package pipe_pkg: opcode localparams, state enum (RUN, MEM_WAIT).
- Sub-module hazard_detect: purely combinational load-use compare. Inputs: opcode_id, rs_id, rt_id, opcode_ex, rt_ex. Output: load_use.
- The FSM, wait counter and perf counter stay in pipe_ctrl.

Test Plan:
- Load-use: opcode_ex=6'h23, rt_ex=5, opcode_id=0, rs_id=5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1, then all enables 1. Repeat with rt_ex=0 -> no stall.
- Branch: branch_taken_ex=1 -> if_id_flush=id_ex_flush=1 in that cycle. Branch plus load-use together -> flushes asserted, pc_en=1.
- Memory wait: mem_access_mm=1 with mem_ready low for 3 cycles -> 3 frozen cycles with mm_wb_flush=1 and mem_req=1. mem_ready high on the 4th -> back to RUN, mm_wb_en=1, mm_wb_flush=0.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_err=1 after 4 MEM_WAIT cycles, state RUN, mem_err stays set.
- Reset mid-wait: rst=1 in MEM_WAIT -> next cycle state RUN, mem_req=0, mem_err=0; during rst all flushes 1.
- With PIPE_CTRL_PERF_EN: 1 load-use plus 3 wait cycles -> perf_stall_cnt=5 (includes the entry cycle of the wait). Without the macro -> 0.
